// File: rtl/xdma_read_mux.sv
// rtl/xdma_read_mux.sv - round-robin merge of N_INP burst streams into one registered output
// Bursts are never interleaved: a granted input keeps the grant until its last beat.
module xdma_read_mux #(
  parameter int unsigned N_INP     = 32'd2,
  parameter type         data_t    = logic,
  parameter int unsigned LOG_N_INP = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  data_t [N_INP-1:0]    inp_data_i,
  input  logic  [N_INP-1:0]    inp_last_i,
  input  logic  [N_INP-1:0]    inp_valid_i,
  output logic  [N_INP-1:0]    inp_ready_o,
  output data_t                oup_data_o,
  output logic                 oup_last_o,
  output logic [LOG_N_INP-1:0] oup_idx_o,
  output logic                 oup_valid_o,
  input  logic                 oup_ready_i
);

  typedef logic [LOG_N_INP-1:0] idx_t;
  typedef logic [LOG_N_INP:0]   sum_t;
  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_e;

  state_e state_q, state_d;
  idx_t   rr_q, rr_d;
  idx_t   lock_idx_q, lock_idx_d;
  idx_t   gnt;
  sum_t   cand;
  logic   gnt_en;
  logic   acc;
  logic   xfer;
  logic   xfer_last;

  data_t  data_q;
  logic   last_q;
  idx_t   idx_q;
  logic   full_q;

  // Grant select; the descending loop lets the smallest offset from rr_q win.
  always_comb begin
    gnt    = lock_idx_q;
    gnt_en = 1'b1;
    cand   = '0;
    if (state_q == ARB) begin
      gnt    = rr_q;
      gnt_en = 1'b0;
      for (int k = int'(N_INP) - 1; k >= 0; k--) begin
        cand = {1'b0, rr_q} + sum_t'(k);
        if (cand >= sum_t'(N_INP)) begin
          cand = cand - sum_t'(N_INP);
        end
        if (inp_valid_i[cand[LOG_N_INP-1:0]]) begin
          gnt    = cand[LOG_N_INP-1:0];
          gnt_en = 1'b1;
        end
      end
    end
  end

  assign acc       = !full_q || oup_ready_i;
  assign xfer      = gnt_en && inp_valid_i[gnt] && acc;
  assign xfer_last = inp_last_i[gnt];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      rr_q       <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_idx_d = lock_idx_q;
    if (xfer) begin
      if (xfer_last) begin
        state_d = ARB;
        rr_d    = (gnt == idx_t'(N_INP - 1)) ? '0 : gnt + idx_t'(1);
      end else begin
        state_d    = LOCK;
        lock_idx_d = gnt;
      end
    end
  end

  always_comb begin
    inp_ready_o = '0;
    if (gnt_en) begin
      inp_ready_o[gnt] = acc;
    end
  end

  // A pop with a concurrent transfer simply reloads the register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      last_q <= 1'b0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else if (xfer) begin
      data_q <= inp_data_i[gnt];
      last_q <= xfer_last;
      idx_q  <= gnt;
      full_q <= 1'b1;
    end else if (oup_ready_i) begin
      full_q <= 1'b0;
    end
  end

  assign oup_data_o  = data_q;
  assign oup_last_o  = last_q;
  assign oup_idx_o   = idx_q;
  assign oup_valid_o = full_q;

endmodule

// File: tb/tb_xdma_read_mux.sv
// tb/tb_xdma_read_mux.sv - directed and random checks of xdma_read_mux against a burst-level model
module tb_xdma_read_mux;
  localparam int N = 4;
  typedef logic [15:0] beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  beat_t [N-1:0]   inp_data;
  logic  [N-1:0]   inp_last;
  logic  [N-1:0]   inp_valid;
  logic  [N-1:0]   inp_ready;
  beat_t           oup_data;
  logic            oup_last;
  logic  [1:0]     oup_idx;
  logic            oup_valid;
  logic            oup_ready;

  xdma_read_mux #(.N_INP(32'(N)), .data_t(beat_t)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .inp_data_i  (inp_data),
    .inp_last_i  (inp_last),
    .inp_valid_i (inp_valid),
    .inp_ready_o (inp_ready),
    .oup_data_o  (oup_data),
    .oup_last_o  (oup_last),
    .oup_idx_o   (oup_idx),
    .oup_valid_o (oup_valid),
    .oup_ready_i (oup_ready)
  );

  always #5 clk = ~clk;

  int    n_chk, n_fail;
  int    m_lock, m_rr, m_idx;
  bit    m_full, m_last;
  beat_t m_data, stall_ref;
  beat_t sent_q[N][$];
  int    exp_idx_q[$];
  int    out_src, last_xfer, sent_total, recv_total;
  int    seq[N], blen[N], bpos[N], budget[N];
  bit    rand_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Locked source wins; otherwise first valid at or after the round-robin pointer.
  function automatic int m_grant();
    if (m_lock >= 0) return m_lock;
    for (int k = 0; k < N; k++) begin
      if (inp_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_lock = -1; m_rr = 0; m_full = 0; m_data = '0; m_last = 0; m_idx = 0;
    out_src = -1; last_xfer = -1;
    for (int i = 0; i < N; i++) sent_q[i].delete();
  endtask

  task automatic new_beat(input int i);
    inp_data[i] = {i[1:0], seq[i][13:0]};
    seq[i]++;
    inp_last[i] = (bpos[i] == blen[i] - 1);
  endtask

  task automatic start(input int i, input int nb, input int bl);
    budget[i] = nb; blen[i] = bl; bpos[i] = 0;
    inp_valid[i] = 1'b1;
    new_beat(i);
  endtask

  task automatic drive_update();
    for (int i = 0; i < N; i++) begin
      if (last_xfer == i) begin
        if (inp_last[i]) begin
          bpos[i] = 0;
          if (rand_mode) blen[i] = int'($urandom_range(1, 4));
        end else begin
          bpos[i]++;
        end
        budget[i]--;
        inp_valid[i] = rand_mode ? ($urandom_range(0, 3) != 0) : (budget[i] > 0);
        if (inp_valid[i]) new_beat(i);
      end else if (rand_mode && !inp_valid[i] && $urandom_range(0, 2) == 0) begin
        inp_valid[i] = 1'b1;
        new_beat(i);
      end
    end
    if (rand_mode) oup_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic cycle();
    int g;
    bit acc;
    bit xfer;
    logic [N-1:0] er;
    @(negedge clk);
    chk("oup_valid", 32'(oup_valid), 32'(m_full));
    if (m_full) begin
      chk("oup_data", 32'(oup_data), 32'(m_data));
      chk("oup_last", 32'(oup_last), 32'(m_last));
      chk("oup_idx", 32'(oup_idx), 32'(m_idx));
    end
    g   = m_grant();
    acc = !m_full || oup_ready;
    er  = '0;
    if (g >= 0 && acc) er[g] = 1'b1;
    chk("inp_ready", 32'(inp_ready), 32'(er));
    if (oup_valid && oup_ready) recv_total++;
    if (m_full && oup_ready) begin
      chk("order", 32'(oup_data), 32'(sent_q[m_idx].pop_front()));
      if (out_src >= 0) chk("interleave", 32'(oup_idx), 32'(out_src));
      out_src = m_last ? -1 : m_idx;
      if (exp_idx_q.size() > 0) chk("dir_idx", 32'(oup_idx), 32'(exp_idx_q.pop_front()));
    end
    xfer = (g >= 0) && inp_valid[g] && acc;
    last_xfer = xfer ? g : -1;
    if (xfer) begin
      sent_q[g].push_back(inp_data[g]);
      sent_total++;
      m_full = 1; m_data = inp_data[g]; m_last = inp_last[g]; m_idx = g;
      if (inp_last[g]) begin
        m_lock = -1;
        m_rr = (g + 1) % N;
      end else begin
        m_lock = g;
      end
    end else if (oup_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
    drive_update();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inp_valid = '0; inp_last = '0; oup_ready = 1'b1;
    for (int i = 0; i < N; i++) begin bpos[i] = 0; budget[i] = 0; blen[i] = 1; end
    model_reset();
    exp_idx_q.delete();
    recv_total = 0; sent_total = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; rand_mode = 0;
    rst_n = 1'b0; inp_data = '0; inp_last = '0; inp_valid = '0; oup_ready = 1'b1;
    for (int i = 0; i < N; i++) begin seq[i] = 0; blen[i] = 1; bpos[i] = 0; budget[i] = 0; end
    model_reset();
    recv_total = 0; sent_total = 0;

    #12;
    chk("reset_valid", 32'(oup_valid), 32'd0);
    chk("reset_data", 32'(oup_data), 32'd0);
    chk("reset_last", 32'(oup_last), 32'd0);
    chk("reset_idx", 32'(oup_idx), 32'd0);
    chk("reset_ready", 32'(inp_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Inputs 1 and 3 alternate with single-beat bursts.
    start(1, 3, 1); start(3, 3, 1);
    exp_idx_q = {1, 3, 1, 3, 1, 3};
    run(9);
    chk("alt_done", 32'(exp_idx_q.size()), 32'd0);

    // Three-beat burst on input 2 holds off input 0.
    do_reset();
    start(1, 1, 1);
    run(3);
    start(2, 3, 3); start(0, 1, 1);
    exp_idx_q = {2, 2, 2, 0};
    run(7);
    chk("burst_done", 32'(exp_idx_q.size()), 32'd0);

    // Output stall with a held beat, then resume.
    do_reset();
    start(0, 8, 1);
    run(2);
    oup_ready = 1'b0;
    stall_ref = m_data;
    repeat (5) begin
      cycle();
      chk("stall_data", 32'(oup_data), 32'(stall_ref));
      chk("stall_rdy", 32'(inp_ready), 32'd0);
    end
    oup_ready = 1'b1;
    run(10);
    chk("stall_count", 32'(recv_total), 32'd8);

    // Pointer at 3 with everyone valid wraps 3,0,1,2.
    do_reset();
    start(2, 1, 1);
    run(3);
    for (int i = 0; i < N; i++) start(i, 1, 1);
    exp_idx_q = {3, 0, 1, 2};
    run(7);
    chk("wrap_done", 32'(exp_idx_q.size()), 32'd0);

    // Reset in the middle of a burst on input 1.
    do_reset();
    start(1, 4, 4);
    run(2);
    start(0, 1, 1);
    run(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(oup_valid), 32'd0);
    chk("midrst_data", 32'(oup_data), 32'd0);
    chk("midrst_idx", 32'(oup_idx), 32'd0);
    model_reset();
    recv_total = 0; sent_total = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_idx_q = {0, 1};
    run(8);
    chk("midrst_done", 32'(exp_idx_q.size()), 32'd0);

    // Random traffic against the model.
    do_reset();
    rand_mode = 1;
    for (int i = 0; i < N; i++) begin blen[i] = int'($urandom_range(1, 4)); bpos[i] = 0; end
    run(3000);
    rand_mode = 0;
    inp_valid = '0;
    oup_ready = 1'b1;
    run(4);
    chk("rand_count", 32'(recv_total), 32'(sent_total));
    for (int i = 0; i < N; i++) chk("rand_drain", 32'(sent_q[i].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xdma_read_mux.md
XDMA_READ_MUX -- requirements
Module: xdma_read_mux

Interface
REQ-001 SHALL have parameter N_INP, default 32'd2, meaning the number of input streams merged into one output (N_INP >= 1).
REQ-002 SHALL have parameter data_t, default logic, meaning the beat payload type.
REQ-003 SHALL have dependent parameter LOG_N_INP, default (N_INP > 1) ? $clog2(N_INP) : 1, meaning the source index width; it is not to be overridden.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 SHALL have port inp_data_i, input, N_INP x data_t: per-input payload.
REQ-007 SHALL have port inp_last_i, input, N_INP bits: per-input last-beat-of-burst flag.
REQ-008 SHALL have port inp_valid_i, input, N_INP bits: per-input valid.
REQ-009 SHALL have port inp_ready_o, output, N_INP bits: per-input ready.
REQ-010 SHALL have port oup_data_o, output, data_t: merged payload.
REQ-011 SHALL have port oup_last_o, output, 1 bit: last flag of the output beat.
REQ-012 SHALL have port oup_idx_o, output, LOG_N_INP bits: index of the input that supplied the output beat.
REQ-013 SHALL have port oup_valid_o, output, 1 bit: output valid.
REQ-014 SHALL have port oup_ready_i, input, 1 bit: output ready.

Function
REQ-015 SHALL hold a one-entry output register (data, last, idx, full flag) driving oup_data_o, oup_last_o, oup_idx_o and oup_valid_o (= full).
REQ-016 SHALL define the accept enable as acc = !full || oup_ready_i, giving one beat per cycle of sustained throughput.
REQ-017 SHALL assert inp_ready_o[g] = acc for the granted index g only, and hold every other inp_ready_o bit at 0.
REQ-018 SHALL transfer an input beat when inp_valid_i[g] && inp_ready_o[g]; the beat appears on the output one cycle later (latency 1).
REQ-019 SHALL implement a two-state FSM, ARB and LOCK, held in a register.
REQ-020 SHALL, in ARB, set g to the first index i with inp_valid_i[i]=1, searching rr_q, rr_q+1, ... with wrap from N_INP-1 to 0.
REQ-021 SHALL, in ARB with no valid input, assert no ready and leave all state unchanged, except that the output register drains.
REQ-022 SHALL, in LOCK, set g to lock_idx_q regardless of the other valids.
REQ-023 SHALL go from ARB to LOCK with lock_idx_q=g when a beat is transferred with last=0.
REQ-024 SHALL go from LOCK back to ARB when a beat is transferred with last=1.
REQ-025 SHALL, when a beat is transferred with last=1 (either state), update rr_q to (g+1) mod N_INP.
REQ-026 SHALL NOT change rr_q on non-last beats.
REQ-027 SHALL, in ARB, transfer a single-beat burst (last=1) without entering LOCK.
REQ-028 SHALL keep output contents stable while oup_valid_o=1 && oup_ready_i=0, and then deassert all inp_ready_o.
REQ-029 SHALL, when an output pop and an input transfer occur in the same cycle, load the register with the new beat and keep full=1.
REQ-030 SHALL clear full on a pop with no concurrent transfer.
REQ-031 SHALL, for N_INP=1, always grant index 0 and drive oup_idx_o=0.
REQ-032 SHALL let inp_ready_o depend combinationally on inp_valid_i and oup_ready_i, and SHALL NOT let oup_valid_o depend combinationally on any input.

Reset
REQ-033 SHALL, while rst_ni=0, force state=ARB, rr_q=0, lock_idx_q=0, full=0 and registered data/last/idx=0, giving oup_valid_o=0, oup_data_o=0, oup_last_o=0 and oup_idx_o=0.
REQ-034 SHALL, on reset mid-burst, drop the held beat and the lock, and restart arbitration from index 0.

Verification (N_INP=4)
REQ-035 SHALL cover: after reset, inp_valid_i=4'b1010, last=1 on all, oup_ready_i=1 -> first output idx=1 one cycle after acceptance, then idx=3, then idx=1, alternating.
REQ-036 SHALL cover: input 2 sends 3 beats (last on beat 3) while input 0 is valid -> outputs idx 2,2,2, then idx 0; inp_ready_o[0]=0 throughout the burst.
REQ-037 SHALL cover: oup_ready_i=0 for 5 cycles with one beat held -> oup_data_o constant and inp_ready_o=0 for those 5 cycles; oup_ready_i=1 resumes 1 beat/cycle with no loss or duplication.
REQ-038 SHALL cover: rr_q=3 and all valid with last=1 -> grant order 3,0,1,2 (wrap).
REQ-039 SHALL cover: rst_ni pulsed low mid-burst on input 1 -> oup_valid_o=0 immediately; after release, input 0 (valid) is granted first.
REQ-040 SHALL cover: random valid/ready/last traffic, compared against a reference model -> per-input beat order preserved, bursts never interleaved, oup_idx_o correct.
